// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word in IDLE and shifts it out MSB first.
// Optional even-parity bit after the data bits when macro PARITY_EN is defined.
module piso_shift_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef PARITY_EN
        PARITY,
`endif
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        if (rst) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
`ifdef PARITY_EN
            par_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (din_valid) begin
                        shreg_d = din;
                        cnt_d   = '0;
                        state_d = SHIFT;
`ifdef PARITY_EN
                        par_d   = ^din;
`endif
                    end
                end
                SHIFT: begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    // Counter saturates at the last bit; the next load clears it.
                    if (cnt_q == LAST) begin
`ifdef PARITY_EN
                        state_d = PARITY;
`else
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef PARITY_EN
                PARITY: state_d = DONE;
`endif
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from next-state values so they can be registered
    // yet still line up with the state they describe.
    always_comb begin
        sout_d        = 1'b0;
        sout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        case (state_d)
            SHIFT: begin
                sout_d        = shreg_d[WIDTH-1];
                sout_valid_d  = 1'b1;
                frame_start_d = (cnt_d == '0);
                busy_d        = 1'b1;
            end
`ifdef PARITY_EN
            PARITY: begin
                sout_d       = par_d;
                sout_valid_d = 1'b1;
                busy_d       = 1'b1;
            end
`endif
            DONE: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        shreg_q       <= shreg_d;
        cnt_q         <= cnt_d;
`ifdef PARITY_EN
        par_q         <= par_d;
`endif
        sout_q        <= sout_d;
        sout_valid_q  <= sout_valid_d;
        frame_start_q <= frame_start_d;
        busy_q        <= busy_d;
        done_q        <= done_d;
    end

    assign din_ready   = (state_q == IDLE) && !rst;
    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: each accepted word pushes its per-cycle expected outputs.
module tb_piso_shift_tx;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             din_valid = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_ready, sout, sout_valid, frame_start, busy, done;

    piso_shift_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame_start(frame_start),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic s;
        logic fs;
        logic d;
        logic b;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '0;
    bit   armed = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   frames_pushed = 0;
    int   frames_aborted = 0;
    int   done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] w);
        for (int i = 0; i < int'(WIDTH); i++)
            exp_q.push_back('{v: 1'b1, s: w[WIDTH-1-i], fs: (i == 0), d: 1'b0, b: 1'b1});
`ifdef PARITY_EN
        exp_q.push_back('{v: 1'b1, s: ^w, fs: 1'b0, d: 1'b0, b: 1'b1});
`endif
        exp_q.push_back('{v: 1'b0, s: 1'b0, fs: 1'b0, d: 1'b1, b: 1'b1});
        frames_pushed++;
    endtask

    // Model of the accept handshake, evaluated at the edge that closes the cycle in cur.
    always @(posedge clk) begin
        if (rst) begin
            if (exp_q.size() > 0) frames_aborted++;
            exp_q.delete();
            armed = 1'b1;
        end else if (armed && !cur.b && din_valid) begin
            push_frame(din);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = '0;
            check("sout_valid", 32'(sout_valid), 32'(cur.v));
            check("sout", 32'(sout), 32'(cur.s));
            check("frame_start", 32'(frame_start), 32'(cur.fs));
            check("done", 32'(done), 32'(cur.d));
            check("busy", 32'(busy), 32'(cur.b));
            check("din_ready", 32'(din_ready), 32'(!rst && !cur.b));
            if (done) done_seen++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        din_valid = 1'b1;
        din       = w;
        cycles(1);
        din_valid = 1'b0;
        din       = ~w;
    endtask

    initial begin
        cycles(1);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);

        send(8'hA5);
        cycles(WIDTH + 4);
        send(8'h07);
        cycles(WIDTH + 4);
        send(8'h03);
        cycles(WIDTH + 4);

        // din_valid held high while din changes every cycle.
        din_valid = 1'b1;
        for (int i = 0; i < 4 * int'(WIDTH + 3); i++) begin
            din = WIDTH'($urandom);
            cycles(1);
        end
        din_valid = 1'b0;
        cycles(WIDTH + 4);

        // Abort 8'hFF after bit 3 has been shown.
        send(8'hFF);
        cycles(3);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(2);
        send(8'h81);
        cycles(WIDTH + 4);

        // Reset wins over a same-edge transfer in IDLE.
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 8'h5A;
        cycles(1);
        rst       = 1'b0;
        din_valid = 1'b0;
        cycles(WIDTH + 4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_pulses", 32'(done_seen), 32'(frames_pushed - frames_aborted));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port din_valid  input  1  parallel word offered.
REQ-005 The block SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 The block SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-007 The block SHALL have port sout  output  1  serial data bit.
REQ-008 The block SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 The block SHALL have port frame_start  output  1  high only during the first bit of a frame.
REQ-010 The block SHALL have port busy  output  1  high whenever the FSM is outside IDLE.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, PARITY and DONE; PARITY exists only when PARITY_EN is defined.
REQ-013 din_ready SHALL be 1 exactly when state==IDLE and rst is low; it is decoded from registered state only, never from din_valid.
REQ-014 Transfer SHALL occur at a rising edge with din_valid=1 and din_ready=1: din loads into a WIDTH-bit shift register, bit counter clears to 0, and state goes to SHIFT.
REQ-015 din and din_valid SHALL be ignored in every state other than IDLE; the loaded word is unaffected by later din changes.
REQ-016 In SHIFT, sout SHALL equal the shift register MSB, sout_valid=1, and each edge SHALL shift left by one (0 into the LSB) and increment the counter.
REQ-017 Bits SHALL be sent MSB first; the first bit appears in the cycle right after the accepting edge (latency 1).
REQ-018 frame_start SHALL be 1 only in the SHIFT cycle with counter==0.
REQ-019 When counter==WIDTH-1 in SHIFT, the next state SHALL be PARITY if PARITY_EN is defined, else DONE; the counter never wraps past WIDTH-1.
REQ-020 In DONE, sout=0, sout_valid=0, done=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 A frame SHALL take WIDTH+1 cycles from accepting edge to return to IDLE (WIDTH+2 with PARITY_EN); the minimum accept-to-accept spacing is one cycle more.
REQ-022 In IDLE, sout=0, sout_valid=0, frame_start=0, busy=0 and done=0.
REQ-023 All outputs except din_ready SHALL be registered (no combinational input-to-output path).

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, clear shift register and counter, and give sout=0, sout_valid=0, frame_start=0, busy=0 and done=0 from the next cycle; din_ready=0 while rst=1 and 1 in the first cycle after rst falls.
REQ-025 rst asserted mid-frame SHALL abort the frame with no done pulse; rst SHALL take priority over a same-edge transfer, so no word is accepted.

Configuration
REQ-026 Macro PARITY_EN: when defined, the PARITY state SHALL follow the last data bit for one cycle with sout = XOR of the loaded word (even parity) and sout_valid=1, frame_start=0.
REQ-027 Without PARITY_EN, no PARITY state or parity logic SHALL exist and frames SHALL be WIDTH bits.

Verification
REQ-028 Reset: rst=1 for 2 cycles then 0 -> all outputs 0 during reset; din_ready=1 in the first cycle after rst falls.
REQ-029 WIDTH=8, din=8'hA5 accepted -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles with sout_valid=1, frame_start only on bit 0, then done=1 for one cycle.
REQ-030 PARITY_EN, din=8'h07 -> 8 data bits 0,0,0,0,0,1,1,1 then parity bit 1, then done; din=8'h03 -> parity bit 0.
REQ-031 din_valid held high continuously with din changing each cycle -> only the words present at IDLE edges are sent, spaced WIDTH+2 cycles apart (WIDTH+3 with PARITY_EN), and din_ready=0 throughout each frame.
REQ-032 rst pulsed for 1 cycle after bit 3 of 8'hFF -> sout_valid drops the next cycle, no done pulse, next word 8'h81 sent intact as 1,0,0,0,0,0,0,1.
REQ-033 din_valid=1 and rst=1 on the same edge in IDLE -> no transfer; sout_valid stays 0.
